imem_loader: RTL and testbench

Boot-time instruction-memory loader for the single-cycle ARM processor: the writer side of the instruction path whose reader is the processor's fetch/decode logic. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory starting at byte address 0. It holds the processor in reset until the announced number of words has been written.

---
 rtl/loader_pkg.sv | 19 +
 rtl/word_assembler.sv | 37 +++
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | loader_pkg: shared types and constants for the imem loader       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | word_assembler: little-endian byte-to-word shift-in register     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  // Only the first three bytes are stored; the fourth is taken straight from
  // byte_in so the owner can act on the complete word on the same edge.
  logic [23:0] r_low;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_low <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_low <= {byte_in, r_low[23:8]};
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign word = {byte_in, r_low};
  // High while the next loaded byte completes the word.
  assign full = (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_loader: boot-time byte-stream loader into instruction memory|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [32:0] C_CAPACITY = 33'(1) << ADDR_W;

  loader_state_t     r_state;
  logic [ADDR_W:0]   r_word_idx;
  logic [31:0]       r_n;

  logic              w_accept;
  logic              w_last_byte;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_idx_inc;

  assign w_accept  = rx_valid & rx_ready;
  assign w_idx_inc = r_word_idx + 1'b1;

  word_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .load    (w_accept),
    .byte_in (rx_data),
    .word    (w_word),
    .full    (w_last_byte)
  );

  // Outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_LEN;
      r_word_idx <= '0;
      r_n        <= '0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wd    <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        S_LEN: begin
          if (w_accept && w_last_byte) begin
            r_n <= w_word;
            if (w_word == '0) begin
              r_state   <= S_RUN;
              rx_ready  <= 1'b0;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else if ({1'b0, w_word} > C_CAPACITY) begin
              r_state  <= S_ERR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept && w_last_byte) begin
            r_state   <= S_WRITE;
            rx_ready  <= 1'b0;
            imem_we   <= 1'b1;
            imem_addr <= 32'(r_word_idx) << 2;
            imem_wd   <= w_word;
          end
        end
        S_WRITE: begin
          r_word_idx <= w_idx_inc;
          if (32'(w_idx_inc) == r_n) begin
            r_state   <= S_RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end else begin
            r_state  <= S_DATA;
            rx_ready <= 1'b1;
          end
        end
        S_RUN, S_ERR: begin
          r_state <= r_state;
        end
        default: begin
          r_state  <= S_ERR;
          rx_ready <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_imem_loader: randomized self-checking bench for imem_loader   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_imem_loader;

  localparam int  ADDR_W = 6;
  localparam int  WORDS  = 1 << ADDR_W;
  localparam longint CAP = WORDS;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        cpu_reset;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  // Reference model: counts accepted bytes and derives every output from that.
  int          m_k = 0;
  int          m_written = 0;
  logic [31:0] m_n = '0;
  logic [31:0] m_buf = '0;
  logic        e_we = 1'b0, e_ready = 1'b1, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0;
  logic [31:0] exp_mem [WORDS] = '{default: 32'h0};

  always @(posedge clk) begin
    if (reset) begin
      m_k = 0; m_written = 0; m_n = '0; m_buf = '0;
      e_we = 1'b0; e_addr = '0; e_wd = '0;
    end else if (e_we) begin
      exp_mem[e_addr[ADDR_W+1:2]] = e_wd;
      m_written = m_written + 1;
      e_we = 1'b0;
    end else if (e_ready && rx_valid) begin
      m_buf[8*(m_k%4) +: 8] = rx_data;
      if (m_k == 3) begin
        m_n = m_buf;
      end else if (m_k >= 4 && (m_k % 4) == 3) begin
        e_we   = 1'b1;
        e_addr = 32'(((m_k - 4) / 4) * 4);
        e_wd   = m_buf;
      end
      m_k = m_k + 1;
    end
    e_err   = (m_k >= 4) && (longint'(m_n) > CAP);
    e_done  = (m_k >= 4) && !e_err && (m_written == int'(m_n)) && !e_we;
    e_ready = !e_err && !e_done && !e_we;
  end

  int          n_checks = 0;
  int          n_pass = 0;
  logic        chk_en = 1'b0;
  int          we_count = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] dut_mem [WORDS] = '{default: 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (rx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t < 200) n_pass++;
    else $display("FAIL accept_timeout: byte %h waited %0d cycles, expected acceptance", b, t);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (gaps && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_mem(input string name, input int n);
    for (int i = 0; i < n; i++) chk(name, dut_mem[i], exp_mem[i]);
  endtask

  initial begin
    int base;
    logic [31:0] words [$];
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("rx_ready",  {31'b0, rx_ready},  {31'b0, e_ready});
          chk("imem_we",   {31'b0, imem_we},   {31'b0, e_we});
          chk("imem_addr", imem_addr, e_addr);
          chk("imem_wd",   imem_wd,   e_wd);
          chk("cpu_reset", {31'b0, cpu_reset}, {31'b0, !e_done});
          chk("done",      {31'b0, done},      {31'b0, e_done});
          chk("error",     {31'b0, error},     {31'b0, e_err});
          if (imem_we === 1'b1) begin
            dut_mem[imem_addr[ADDR_W+1:2]] = imem_wd;
            we_count++;
            last_addr = imem_addr;
          end
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    do_reset();
    chk("rst_rx_ready",  {31'b0, rx_ready},  32'd1);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rst_done",      {31'b0, done},      32'd0);
    chk("rst_error",     {31'b0, error},     32'd0);
    chk("rst_imem_we",   {31'b0, imem_we},   32'd0);
    chk("rst_imem_addr", imem_addr,          32'd0);

    // Two-word load
    base = we_count;
    send_word(32'd2, 1'b0);
    send_word(32'hE04F000F, 1'b0);
    send_word(32'hE2802005, 1'b0);
    idle(3);
    chk("two_writes", 32'(we_count - base), 32'd2);
    chk("two_mem0",   dut_mem[0], 32'hE04F000F);
    chk("two_mem1",   dut_mem[1], 32'hE2802005);
    chk("model_mem0", exp_mem[0], 32'hE04F000F);
    chk("model_mem1", exp_mem[1], 32'hE2802005);
    chk("two_done",   {31'b0, done}, 32'd1);

    // Empty program; extra bytes afterwards must be ignored
    do_reset();
    base = we_count;
    send_word(32'd0, 1'b0);
    rx_data = 8'hFF; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    idle(1);
    chk("empty_writes", 32'(we_count - base), 32'd0);
    chk("empty_done",   {31'b0, done}, 32'd1);

    // Overlength header
    do_reset();
    base = we_count;
    send_word(32'd65, 1'b0);
    idle(3);
    chk("ovl_error",     {31'b0, error},     32'd1);
    chk("ovl_rx_ready",  {31'b0, rx_ready},  32'd0);
    chk("ovl_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("ovl_writes",    32'(we_count - base), 32'd0);
    do_reset();
    chk("ovl_reset_ready", {31'b0, rx_ready}, 32'd1);

    // Random short programs
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      do_reset();
      send_word(32'(n), 1'b1);
      for (int i = 0; i < n; i++) send_word($urandom, 1'b1);
      idle(3);
      check_mem("rand_mem", n);
    end

    // Full-capacity handshake stress
    do_reset();
    base = we_count;
    send_word(32'(WORDS), 1'b1);
    for (int i = 0; i < WORDS; i++) send_word($urandom, 1'b1);
    idle(3);
    chk("full_writes",    32'(we_count - base), 32'(WORDS));
    chk("full_last_addr", last_addr, 32'h0000_00FC);
    chk("full_done",      {31'b0, done}, 32'd1);
    check_mem("full_mem", WORDS);

    // Reset mid-word, with a byte offered on the reset edge
    do_reset();
    base = we_count;
    send_word(32'd3, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx_data = 8'h33; rx_valid = 1'b1;
    do_reset();
    chk("mid_writes", 32'(we_count - base), 32'd0);
    words = '{32'hE3A00001, 32'hEAFFFFFE};
    send_word(32'd2, 1'b1);
    foreach (words[i]) send_word(words[i], 1'b1);
    idle(3);
    chk("mid_mem0",  dut_mem[0], 32'hE3A00001);
    chk("mid_mem1",  dut_mem[1], 32'hEAFFFFFE);
    chk("mid_total", 32'(we_count - base), 32'd2);
    check_mem("mid_mem", 2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
